// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, single-outstanding imem req/ack, output register with stall and redirect flush.
// Optional FETCH_PERF_CNT_EN adds fetch_count/stall_count performance counters.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic        inst_valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {S_REQ = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t            state, state_nx;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   flush_addr;
  logic [XLEN-1:0]   redirect_target;
  logic              fire;

  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign fire            = (state == S_REQ) && imem_req && imem_ack;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_REQ;
    else       state <= state_nx;
  end

  // Next-state: a redirect over an un-acked request must wait out that request in S_FLUSH
  always_comb begin
    state_nx = state;
    case (state)
      S_REQ: begin
        if (redirect_valid && imem_req && !imem_ack) state_nx = S_FLUSH;
      end
      S_FLUSH: begin
        if (imem_ack) state_nx = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
  end

  // Outputs: request only when the output register can take the result
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (!reset) begin
      case (state)
        S_REQ:   imem_req = !inst_valid || !stall;
        S_FLUSH: imem_req = 1'b1;
        default: imem_req = 1'b0;
      endcase
    end
    if (state == S_FLUSH) imem_addr = flush_addr;
  end

  // PC, flush address and decoder output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      flush_addr  <= '0;
      instruction <= '0;
      inst_pc     <= '0;
      inst_valid  <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= redirect_target;
      inst_valid <= 1'b0;
      if ((state == S_REQ) && imem_req && !imem_ack) flush_addr <= pc;
    end else if (fire) begin
      instruction <= imem_rdata;
      inst_pc     <= pc;
      inst_valid  <= 1'b1;
      pc          <= pc + PC_INC;
    end else if (inst_valid && !stall) begin
      inst_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Counters wrap naturally at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fire && !redirect_valid) fetch_count <= fetch_count + 32'd1;
      if (inst_valid && stall)     stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a switchable zero-wait / manual-ack memory model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        inst_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic zw;
  logic ack_man;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0232_4020 : (a ^ 32'h1357_9BDF);
  endfunction

  assign imem_ack   = zw ? imem_req : ack_man;
  assign imem_rdata = mem(imem_addr);

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .instruction(instruction), .inst_pc(inst_pc), .inst_valid(inst_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; zw = 1'b1; ack_man = 1'b0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_pc", inst_pc, 32'h0);

    // Zero-wait streaming from RESET_PC
    reset = 1'b0; #1;
    check("c0_req", 32'(imem_req), 32'd1);
    check("c0_addr", imem_addr, 32'h0);
    tick();
    check("c1_instr", instruction, 32'h0232_4020);
    check("c1_pc", inst_pc, 32'h0);
    check("c1_valid", 32'(inst_valid), 32'd1);
    check("c1_addr", imem_addr, 32'd4);
    tick();
    check("c2_pc", inst_pc, 32'd4);
    check("c2_addr", imem_addr, 32'd8);
    tick();
    check("c3_pc", inst_pc, 32'd8);
    check("c3_addr", imem_addr, 32'd12);

    // Stall holds the entry and suppresses requests
    stall = 1'b1; #1;
    check("stl_req0", 32'(imem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stl_pc", inst_pc, 32'd8);
      check("stl_instr", instruction, mem(32'd8));
      check("stl_valid", 32'(inst_valid), 32'd1);
      check("stl_req", 32'(imem_req), 32'd0);
    end
    stall = 1'b0; #1;
    check("rel_req", 32'(imem_req), 32'd1);
    check("rel_addr", imem_addr, 32'd12);
    tick();
    check("rel_pc", inst_pc, 32'd12);
    check("rel_instr", instruction, mem(32'd12));

    // Redirect during an un-acked fetch of 16
    zw = 1'b0; ack_man = 1'b0;
    tick();
    check("acc_valid", 32'(inst_valid), 32'd0);
    check("f16_addr", imem_addr, 32'd16);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0; #1;
    check("fl_req", 32'(imem_req), 32'd1);
    check("fl_addr", imem_addr, 32'd16);
    check("fl_valid", 32'(inst_valid), 32'd0);
    tick();
    check("fl_addr2", imem_addr, 32'd16);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0; #1;
    check("fl_drop_valid", 32'(inst_valid), 32'd0);
    check("rd_addr", imem_addr, 32'h0000_0100);
    check("rd_req", 32'(imem_req), 32'd1);

    // Three-cycle ack latency
    tick();
    check("lat_addr1", imem_addr, 32'h100);
    check("lat_valid1", 32'(inst_valid), 32'd0);
    tick();
    check("lat_addr2", imem_addr, 32'h100);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0; #1;
    check("lat_valid", 32'(inst_valid), 32'd1);
    check("lat_pc", inst_pc, 32'h100);
    check("lat_instr", instruction, mem(32'h100));
    check("lat_next", imem_addr, 32'h104);

    // Redirect with same-cycle ack, target low bits masked, then PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; ack_man = 1'b1;
    tick();
    redirect_valid = 1'b0; ack_man = 1'b0; #1;
    check("rdack_valid", 32'(inst_valid), 32'd0);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    check("wrap_req", 32'(imem_req), 32'd1);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0; #1;
    check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_valid", 32'(inst_valid), 32'd1);
    check("wrap_next", imem_addr, 32'h0);

    // Async reset during an outstanding request; ack during reset ignored
    tick();
    check("pend_req", 32'(imem_req), 32'd1);
    #2 reset = 1'b1; #1;
    check("arst_req", 32'(imem_req), 32'd0);
    check("arst_valid", 32'(inst_valid), 32'd0);
    ack_man = 1'b1;
    tick();
    check("arst_req2", 32'(imem_req), 32'd0);
    check("arst_valid2", 32'(inst_valid), 32'd0);
    ack_man = 1'b0;
    reset = 1'b0; #1;
    check("rs_addr", imem_addr, 32'h0);
    check("rs_req", 32'(imem_req), 32'd1);
    zw = 1'b1;
    tick();
    check("rs_instr", instruction, 32'h0232_4020);
    check("rs_pc", inst_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
Instruction fetch stage directly upstream of the decoder/register-read stage. Holds the program counter and issues word reads to instruction memory over a req/ack handshake. Presents each fetched 32-bit instruction, with its PC, in an output register that the decoder consumes. Supports decoder back-pressure (stall) and branch/jump redirects with discard of in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0.
PC_INC, 4, byte increment per sequential fetch.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  read request to instruction memory.
imem_addr  output  32  word-aligned byte address; valid while imem_req=1.
imem_ack  input  1  memory has returned imem_rdata this cycle.
imem_rdata  input  32  instruction word; sampled only when imem_req=1 and imem_ack=1.
stall  input  1  decoder cannot accept this cycle.
redirect_valid  input  1  branch/jump taken; load redirect_pc.
redirect_pc  input  32  redirect target; bits [1:0] are forced to 0 internally.
instruction  output  32  fetched instruction to the decoder.
inst_pc  output  32  PC of instruction.
inst_valid  output  1  instruction/inst_pc hold a valid entry.

Behaviour:
- Reset (async): pc=RESET_PC, state=S_REQ, imem_req=0 during reset, instruction=0, inst_pc=0, inst_valid=0, flush flag=0.
- imem_req=1 only in states S_REQ and S_FLUSH. imem_addr=pc in S_REQ; in S_FLUSH it holds the original address. imem_addr is stable while req=1 and no ack has been seen. At most one outstanding request.
- Accept: the decoder takes an entry on a cycle with inst_valid=1 and stall=0.
- S_REQ: request issued only when the output register is empty, or is accepted this cycle. Otherwise imem_req=0 and the state holds (S_HOLD behaviour).
- On ack in S_REQ with no redirect:
  - instruction<=imem_rdata; inst_pc<=pc; inst_valid<=1; pc<=pc+PC_INC.
  - Remain in S_REQ.
  - Throughput is 1 instr/cycle when ack is combinational and stall=0.
  - Latency is 1 cycle from the req&ack cycle to inst_valid.
- No ack: request is held with the same address. No timeout.
- Accept with no new ack: inst_valid<=0 next cycle.
- Stall with inst_valid=1: instruction, inst_pc and inst_valid hold unchanged. No new request is issued.
- Redirect (highest priority, any state):
  - pc<=redirect_pc & ~3; inst_valid<=0.
  - If a request is outstanding and un-acked this cycle: go to S_FLUSH. Keep req/addr stable, wait for ack, discard that data, then return to S_REQ at the new pc.
  - If ack arrives in the same cycle as the redirect: data is discarded and the next state is S_REQ.
  - Redirect while already in S_FLUSH: update pc; remain in S_FLUSH.
- PC wrap: 32'hFFFF_FFFC + 4 -> 32'h0000_0000. No error.
- Reset asserted mid-request: req drops immediately (async). The pending ack is ignored after reset.
- ack while imem_req=0: ignored.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds output ports fetch_count [31:0] and stall_count [31:0].
  - fetch_count increments on each accepted (non-discarded) ack.
  - stall_count increments each cycle inst_valid=1 and stall=1.
  - Both clear on reset and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset with RESET_PC=0 and zero-wait memory (ack=req) returning 32'h0232_4020 at addr 0 -> cycle 1: instruction=32'h0232_4020, inst_pc=0, inst_valid=1; imem_addr then 4, 8, 12 on consecutive cycles.
- Memory with 3-cycle ack latency -> imem_addr=0 held stable 3 cycles; inst_valid rises 1 cycle after ack; next req addr=4.
- stall=1 for 4 cycles while inst_valid=1 with instruction from addr 8 -> outputs unchanged, imem_req=0; after release the fetch of addr 12 proceeds.
- redirect_valid with redirect_pc=32'h0000_0103 during an un-acked fetch of addr 16 -> addr 16 held until ack, data dropped, inst_valid stays 0, next req addr=32'h0000_0100.
- pc=32'hFFFF_FFFC fetch acked -> next imem_addr=0.
- Assert reset during an outstanding request, then apply ack -> imem_req=0 immediately, ack ignored, fetch restarts at RESET_PC.
